// File: rtl/dds_ctrl_fsm.sv
// Front-panel control FSM for the DDS generator: button pulses edit waveform, frequency and amplitude.
// Optional DDS_CTRL_SHADOW_EN: edits go to shadow registers, committed on the AMP->RUN Mode pulse.
module dds_ctrl_fsm #(
   parameter int unsigned FREQ_W     = 24,
   parameter int unsigned FTW_W      = 32,
   parameter int unsigned FREQ_MIN   = 1,
   parameter int unsigned FREQ_MAX   = 1000000,
   parameter int unsigned FREQ_DEF   = 1000,
   parameter int unsigned FTW_PER_HZ = 23456248,
   parameter int unsigned AMP_DEF    = 7
) (
   input  logic              Fg_CLK,
   input  logic              Ext_RESETn,
   input  logic              iBtnMode,
   input  logic              iBtnSel,
   input  logic              iBtnUp,
   input  logic              iBtnDown,
   output logic [1:0]        oState,
   output logic [1:0]        oWaveSel,
   output logic [FREQ_W-1:0] oFreqHz,
   output logic [2:0]        oStepSel,
   output logic [2:0]        oAmpSel,
   output logic [FTW_W-1:0]  oFtw,
   output logic              oUpdate
);

   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_WAVE = 2'd1, ST_FREQ = 2'd2, ST_AMP = 2'd3} state_t;
   typedef logic [FREQ_W:0]     freq_ext_t;
   typedef logic [FTW_W+15:0]   prod_t;

   localparam prod_t                PROD_DEF = prod_t'(FREQ_DEF) * prod_t'(FTW_PER_HZ);
   localparam logic [FTW_W-1:0]     FTW_DEF  = PROD_DEF[FTW_W+15:16];
   localparam logic [FREQ_W-1:0]    F_DEF    = FREQ_W'(FREQ_DEF);
   localparam logic [FREQ_W-1:0]    F_MIN    = FREQ_W'(FREQ_MIN);
   localparam logic [FREQ_W-1:0]    F_MAX    = FREQ_W'(FREQ_MAX);
   localparam logic [2:0]           A_DEF    = 3'(AMP_DEF);

   logic [3:0]        btn_q;
   state_t            state_q, state_d;
   logic [1:0]        wave_q, wave_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic [2:0]        step_q, step_d;
   logic [2:0]        amp_q, amp_d;
   logic              chg_q, chg_d;
   logic [FTW_W-1:0]  ftw_q, ftw_d;
   logic              upd_q;

   logic              act_mode, act_sel, act_up, act_down;
   logic [1:0]        ed_wave, wave_n;
   logic [FREQ_W-1:0] ed_freq, freq_n;
   logic [2:0]        ed_amp, amp_n;
   freq_ext_t         step_val, freq_up;
   prod_t             prod;

`ifdef DDS_CTRL_SHADOW_EN
   logic [1:0]        wave_sh_q;
   logic [FREQ_W-1:0] freq_sh_q;
   logic [2:0]        amp_sh_q;
   assign ed_wave = wave_sh_q;
   assign ed_freq = freq_sh_q;
   assign ed_amp  = amp_sh_q;
`else
   assign ed_wave = wave_q;
   assign ed_freq = freq_q;
   assign ed_amp  = amp_q;
`endif

   // Priority Mode > Sel > Up > Down on the registered pulses.
   assign act_mode = btn_q[3];
   assign act_sel  = ~btn_q[3] & btn_q[2];
   assign act_up   = ~btn_q[3] & ~btn_q[2] & btn_q[1];
   assign act_down = ~btn_q[3] & ~btn_q[2] & ~btn_q[1] & btn_q[0];

   always_comb begin
      case (step_q)
         3'd1:    step_val = freq_ext_t'(10);
         3'd2:    step_val = freq_ext_t'(100);
         3'd3:    step_val = freq_ext_t'(1000);
         3'd4:    step_val = freq_ext_t'(10000);
         3'd5:    step_val = freq_ext_t'(100000);
         default: step_val = freq_ext_t'(1);
      endcase
      freq_up = {1'b0, ed_freq} + step_val;
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      wave_n  = ed_wave;
      freq_n  = ed_freq;
      amp_n   = ed_amp;
      if (act_mode) begin
         state_d = state_t'(state_q + 2'd1);
      end else if (act_sel && state_q != ST_RUN) begin
         step_d = (step_q >= 3'd5) ? 3'd0 : step_q + 3'd1;
      end else if (act_up || act_down) begin
         case (state_q)
            ST_WAVE: wave_n = act_up ? ed_wave + 2'd1 : ed_wave - 2'd1;
            ST_FREQ: begin
               if (act_up)
                  freq_n = (freq_up > freq_ext_t'(FREQ_MAX)) ? F_MAX : freq_up[FREQ_W-1:0];
               else if ({1'b0, ed_freq} < freq_ext_t'(FREQ_MIN) + step_val)
                  freq_n = F_MIN;
               else
                  freq_n = ed_freq - step_val[FREQ_W-1:0];
            end
            ST_AMP: begin
               if (act_up)
                  amp_n = (ed_amp == 3'd7) ? 3'd7 : ed_amp + 3'd1;
               else
                  amp_n = (ed_amp == 3'd0) ? 3'd0 : ed_amp - 3'd1;
            end
            default: ;
         endcase
      end
`ifdef DDS_CTRL_SHADOW_EN
      wave_d = wave_q;
      freq_d = freq_q;
      amp_d  = amp_q;
      if (act_mode && state_q == ST_AMP) begin
         wave_d = wave_sh_q;
         freq_d = freq_sh_q;
         amp_d  = amp_sh_q;
      end
`else
      wave_d = wave_n;
      freq_d = freq_n;
      amp_d  = amp_n;
`endif
      chg_d = (wave_d != wave_q) || (freq_d != freq_q) || (amp_d != amp_q);
   end

   // Multiply stage always tracks the committed frequency, so oFtw lags oFreqHz by one cycle.
   assign prod  = prod_t'(freq_q) * prod_t'(FTW_PER_HZ);
   assign ftw_d = FTW_W'(prod >> 16);

   always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
      if (!Ext_RESETn) begin
         btn_q   <= '0;
         state_q <= ST_RUN;
         wave_q  <= '0;
         freq_q  <= F_DEF;
         step_q  <= '0;
         amp_q   <= A_DEF;
         chg_q   <= 1'b0;
         ftw_q   <= FTW_DEF;
         upd_q   <= 1'b0;
`ifdef DDS_CTRL_SHADOW_EN
         wave_sh_q <= '0;
         freq_sh_q <= F_DEF;
         amp_sh_q  <= A_DEF;
`endif
      end else begin
         btn_q   <= {iBtnMode, iBtnSel, iBtnUp, iBtnDown};
         state_q <= state_d;
         wave_q  <= wave_d;
         freq_q  <= freq_d;
         step_q  <= step_d;
         amp_q   <= amp_d;
         chg_q   <= chg_d;
         ftw_q   <= ftw_d;
         upd_q   <= chg_q;
`ifdef DDS_CTRL_SHADOW_EN
         wave_sh_q <= wave_n;
         freq_sh_q <= freq_n;
         amp_sh_q  <= amp_n;
`endif
      end
   end

   assign oState   = state_q;
   assign oWaveSel = wave_q;
   assign oFreqHz  = freq_q;
   assign oStepSel = step_q;
   assign oAmpSel  = amp_q;
   assign oFtw     = ftw_q;
   assign oUpdate  = upd_q;

endmodule

// File: tb/tb_dds_ctrl_fsm.sv
// Directed bench for dds_ctrl_fsm (default build, no shadow registers).
module tb_dds_ctrl_fsm;

   logic        Fg_CLK = 1'b0;
   logic        Ext_RESETn = 1'b0;
   logic        iBtnMode = 1'b0, iBtnSel = 1'b0, iBtnUp = 1'b0, iBtnDown = 1'b0;
   logic [1:0]  oState, oWaveSel;
   logic [23:0] oFreqHz;
   logic [2:0]  oStepSel, oAmpSel;
   logic [31:0] oFtw;
   logic        oUpdate;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned upd_cnt = 0;
   int unsigned cnt0;

   dds_ctrl_fsm #(.FREQ_W(24), .FTW_W(32)) dut (
      .Fg_CLK(Fg_CLK), .Ext_RESETn(Ext_RESETn),
      .iBtnMode(iBtnMode), .iBtnSel(iBtnSel), .iBtnUp(iBtnUp), .iBtnDown(iBtnDown),
      .oState(oState), .oWaveSel(oWaveSel), .oFreqHz(oFreqHz), .oStepSel(oStepSel),
      .oAmpSel(oAmpSel), .oFtw(oFtw), .oUpdate(oUpdate)
   );

   always #5 Fg_CLK = ~Fg_CLK;

   always @(negedge Fg_CLK) if (oUpdate) upd_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Returns at the falling edge just after the sampling edge N.
   task automatic press(input logic m, input logic s, input logic u, input logic d);
      @(negedge Fg_CLK);
      {iBtnMode, iBtnSel, iBtnUp, iBtnDown} = {m, s, u, d};
      @(negedge Fg_CLK);
      {iBtnMode, iBtnSel, iBtnUp, iBtnDown} = 4'b0000;
   endtask

   task automatic act(input logic m, input logic s, input logic u, input logic d);
      press(m, s, u, d);
      repeat (3) @(negedge Fg_CLK);
   endtask

   initial begin
      repeat (3) @(negedge Fg_CLK);
      check("rst_state", oState, 0);
      check("rst_wave", oWaveSel, 0);
      check("rst_freq", oFreqHz, 1000);
      check("rst_step", oStepSel, 0);
      check("rst_amp", oAmpSel, 7);
      check("rst_ftw", oFtw, 357913);
      check("rst_upd", oUpdate, 0);
      Ext_RESETn = 1'b1;
      repeat (10) @(negedge Fg_CLK);
      check("idle_state", oState, 0);
      check("idle_freq", oFreqHz, 1000);
      check("idle_ftw", oFtw, 357913);
      check("idle_upd_cnt", upd_cnt, 0);

      act(1, 0, 0, 0); act(1, 0, 0, 0);
      check("freq_state", oState, 2);
      repeat (3) act(0, 1, 0, 0);
      check("step_1k", oStepSel, 3);
      check("sel_no_upd", upd_cnt, 0);

      // Exact latency of the first Up.
      press(0, 0, 1, 0);
      check("up1_n0_freq", oFreqHz, 1000);
      @(negedge Fg_CLK);
      check("up1_n1_freq", oFreqHz, 2000);
      check("up1_n1_upd", oUpdate, 0);
      check("up1_n1_ftw", oFtw, 357913);
      @(negedge Fg_CLK);
      check("up1_n2_upd", oUpdate, 1);
      check("up1_n2_ftw", oFtw, 715827);
      @(negedge Fg_CLK);
      check("up1_n3_upd", oUpdate, 0);
      act(0, 0, 1, 0);
      check("up2_freq", oFreqHz, 3000);
      check("up2_ftw", oFtw, 1073741);
      check("up2_upd_cnt", upd_cnt, 2);

      act(0, 1, 0, 0); act(0, 1, 0, 0);
      check("step_100k", oStepSel, 5);
      act(0, 0, 0, 1);
      check("dn_sat_min", oFreqHz, 1);
      repeat (9) act(0, 0, 1, 0);
      check("up9", oFreqHz, 900001);
      act(0, 1, 0, 0);
      check("step_wrap", oStepSel, 0);
      act(0, 0, 0, 1);
      check("dn_step1", oFreqHz, 900000);
      repeat (4) act(0, 1, 0, 0);
      repeat (5) act(0, 0, 1, 0);
      check("f_950k", oFreqHz, 950000);
      check("ftw_950k", oFtw, 340018243);
      act(0, 1, 0, 0);
      act(0, 0, 1, 0);
      check("f_max", oFreqHz, 1000000);
      check("ftw_max", oFtw, 357913940);
      cnt0 = upd_cnt;
      act(0, 0, 1, 0);
      check("f_max_hold", oFreqHz, 1000000);
      check("f_max_no_upd", upd_cnt, cnt0);
      repeat (10) act(0, 0, 0, 1);
      check("f_down_to_min", oFreqHz, 1);
      act(0, 1, 0, 0);
      cnt0 = upd_cnt;
      act(0, 0, 0, 1);
      check("f_min_hold", oFreqHz, 1);
      check("f_min_no_upd", upd_cnt, cnt0);
      act(0, 1, 1, 0);
      check("sel_over_up_step", oStepSel, 1);
      check("sel_over_up_freq", oFreqHz, 1);

      repeat (3) act(1, 0, 0, 0);
      check("wave_state", oState, 1);
      act(0, 0, 0, 1);
      check("wave_dn_wrap", oWaveSel, 3);
      act(0, 0, 1, 0);
      check("wave_up_wrap", oWaveSel, 0);
      act(1, 0, 0, 0); act(1, 0, 0, 0);
      check("amp_state", oState, 3);
      cnt0 = upd_cnt;
      act(0, 0, 1, 0);
      check("amp_sat7", oAmpSel, 7);
      check("amp_sat_no_upd", upd_cnt, cnt0);
      act(0, 0, 0, 1);
      check("amp_dn", oAmpSel, 6);
      check("amp_dn_upd", upd_cnt, cnt0 + 1);
      act(0, 0, 1, 0);
      check("amp_up", oAmpSel, 7);

      repeat (3) act(1, 0, 0, 0);
      check("back_freq", oState, 2);
      cnt0 = upd_cnt;
      act(1, 0, 1, 0);
      check("mode_wins_state", oState, 3);
      check("mode_wins_freq", oFreqHz, 1);
      check("mode_no_upd", upd_cnt, cnt0);
      act(1, 0, 0, 0);
      act(0, 0, 1, 0);
      act(0, 1, 0, 0);
      check("run_state", oState, 0);
      check("run_up_ign", oFreqHz, 1);
      check("run_sel_ign", oStepSel, 1);
      check("run_no_upd", upd_cnt, cnt0);

      // Reset while an Up is in flight.
      act(1, 0, 0, 0); act(1, 0, 0, 0);
      cnt0 = upd_cnt;
      press(0, 0, 1, 0);
      Ext_RESETn = 1'b0;
      @(negedge Fg_CLK);
      check("rst_mid_ftw", oFtw, 357913);
      check("rst_mid_upd", oUpdate, 0);
      check("rst_mid_state", oState, 0);
      check("rst_mid_freq", oFreqHz, 1000);
      @(negedge Fg_CLK);
      Ext_RESETn = 1'b1;
      repeat (4) @(negedge Fg_CLK);
      check("rst_mid_no_upd", upd_cnt, cnt0);
      check("rst_mid_ftw2", oFtw, 357913);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
